axi_lite_param_regs: RTL and testbench

- AXI4-Lite slave register bank: the responder end of the AXI4-Lite master BFM used in the block-design benches.
- Holds NUM_REGS 32-bit algorithm parameter words and exposes them to the datapath as one flat bus.
- Pulses a per-write strobe so that downstream logic can re-latch parameters.
- Sits behind the AXI interconnect at the ctl slave base address; only the low address bits are decoded.

---
 rtl/axi_lite_pkg.sv | 33 +++
 rtl/axi_lite_param_regs.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_param_regs.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and width helpers
// for the parameter register bank.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LATCH,
    R_DATA
  } rd_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single-register bank still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/axi_lite_param_regs.sv
// AXI4-Lite slave holding NUM_REGS parameter words, exported flat on params_o,
// with a one-cycle strobe on every committed write.
module axi_lite_param_regs
  import axi_lite_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_REGS           = 4,
  parameter logic [31:0] RESET_VALUE        = 32'h0
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] params_o,
  output logic                                param_wr_o,
  output logic [idx_width(NUM_REGS)-1:0]      param_wr_idx_o
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int AIW = AW - 2;
  localparam int WIW = idx_width(NUM_REGS);

  logic [DW-1:0] regs [NUM_REGS];

  wr_state_t      w_state, w_next;
  logic           aw_have, w_have, commit, aw_hs, w_hs, wr_in_range;
  logic [AIW-1:0] aw_idx;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;

  rd_state_t      r_state, r_next;
  logic [AIW-1:0] ar_idx;
  logic [DW-1:0]  rd_word;
  logic           rd_hit;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_in_range = 32'(aw_idx) < 32'(NUM_REGS);

  always_comb begin
    w_next        = w_state;
    commit        = 1'b0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = !aw_have;
        S_AXI_WREADY  = !w_have;
        if (aw_have && w_have) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state        <= W_IDLE;
      aw_have        <= 1'b0;
      w_have         <= 1'b0;
      aw_idx         <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      S_AXI_BRESP    <= RESP_OKAY;
      param_wr_o     <= 1'b0;
      param_wr_idx_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else begin
      w_state    <= w_next;
      param_wr_o <= 1'b0;
      if (aw_hs) begin
        aw_have <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[AW-1:2];
      end
      if (w_hs) begin
        w_have <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_have     <= 1'b0;
        w_have      <= 1'b0;
        S_AXI_BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        param_wr_o  <= wr_in_range;
        if (wr_in_range) param_wr_idx_o <= aw_idx[WIW-1:0];
        for (int i = 0; i < NUM_REGS; i++) begin
          if (32'(aw_idx) == 32'(i)) begin
            for (int k = 0; k < SW; k++) begin
              if (w_strb[k]) regs[i][8*k +: 8] <= w_data[8*k +: 8];
            end
          end
        end
      end
    end
  end

  // ARREADY drops as soon as the address is taken, so no second AR can slip
  // in during the latch cycle before RVALID rises.
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) r_next = R_LATCH;
      end
      R_LATCH: r_next = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_idx = S_AXI_ARADDR[AW-1:2];

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == 32'(i)) begin
        rd_word = regs[i];
        rd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RDATA <= rd_word;
        S_AXI_RRESP <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    params_o = '0;
    for (int i = 0; i < NUM_REGS; i++) params_o[DW*i +: DW] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_param_regs.sv
// Bench for axi_lite_param_regs: a 4-register and a 3-register instance share
// one master; a transaction-level model predicts both on every cycle.
module tb_axi_lite_param_regs;
  import axi_lite_pkg::*;

  localparam int LIM = 50;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        awready [2], wready [2], bvalid [2], arready [2], rvalid [2], pwr [2];
  logic [1:0]  bresp [2], rresp [2], pidx [2];
  logic [31:0] rdata [2];
  logic [127:0] params4;
  logic [95:0]  params3;

  always #5 aclk = ~aclk;

  axi_lite_param_regs #(.NUM_REGS(4)) u_dut4 (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready[0]),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready[0]),
    .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready),
    .params_o(params4), .param_wr_o(pwr[0]), .param_wr_idx_o(pidx[0])
  );

  axi_lite_param_regs #(.NUM_REGS(3)) u_dut3 (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready[1]),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready[1]),
    .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready),
    .params_o(params3), .param_wr_o(pwr[1]), .param_wr_idx_o(pidx[1])
  );

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout %s: no response, required within %0d cycles", what, LIM);
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_regs [2][4];
  bit          m_aw_have, m_w_have, m_bvalid;
  int          m_aw_idx, m_rphase;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rd [2];
  logic [1:0]  m_rr [2], m_br [2];
  bit          m_pw [2];
  int          m_pidx [2];
  bit          e_aw, e_w, e_commit, e_bhs, e_ar, e_rhs;

  function automatic int nregs(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  always @(posedge aclk) begin
    if (areset) begin
      m_aw_have = 0; m_w_have = 0; m_bvalid = 0; m_rphase = 0;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) m_regs[d][i] = '0;
        m_rd[d] = '0; m_rr[d] = RESP_OKAY; m_br[d] = RESP_OKAY; m_pw[d] = 0; m_pidx[d] = 0;
      end
    end else begin
      e_aw     = awvalid && !m_aw_have && !m_bvalid;
      e_w      = wvalid && !m_w_have && !m_bvalid;
      e_commit = m_aw_have && m_w_have;
      e_bhs    = m_bvalid && bready;
      e_ar     = arvalid && (m_rphase == 0);
      e_rhs    = (m_rphase == 2) && rready;
      // a read snapshots the bank as it stood before any same-edge write
      if (e_ar) begin
        for (int d = 0; d < 2; d++) begin
          if (int'(araddr[3:2]) < nregs(d)) begin
            m_rd[d] = m_regs[d][araddr[3:2]]; m_rr[d] = RESP_OKAY;
          end else begin
            m_rd[d] = '0; m_rr[d] = RESP_SLVERR;
          end
        end
      end
      if (e_ar) m_rphase = 1;
      else if (m_rphase == 1) m_rphase = 2;
      else if (e_rhs) m_rphase = 0;
      for (int d = 0; d < 2; d++) m_pw[d] = 0;
      if (e_commit) begin
        for (int d = 0; d < 2; d++) begin
          if (m_aw_idx < nregs(d)) begin
            m_regs[d][m_aw_idx] = merge(m_regs[d][m_aw_idx], m_wdata, m_wstrb);
            m_pw[d] = 1; m_pidx[d] = m_aw_idx; m_br[d] = RESP_OKAY;
          end else begin
            m_br[d] = RESP_SLVERR;
          end
        end
        m_bvalid = 1; m_aw_have = 0; m_w_have = 0;
      end else if (e_bhs) begin
        m_bvalid = 0;
      end
      if (e_aw) begin m_aw_have = 1; m_aw_idx = int'(awaddr[3:2]); end
      if (e_w)  begin m_w_have = 1; m_wdata = wdata; m_wstrb = wstrb; end
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("awready%0d", d), awready[d], !m_aw_have && !m_bvalid);
        chk($sformatf("wready%0d", d), wready[d], !m_w_have && !m_bvalid);
        chk($sformatf("bvalid%0d", d), bvalid[d], m_bvalid);
        if (m_bvalid) chk($sformatf("bresp%0d", d), bresp[d], m_br[d]);
        chk($sformatf("arready%0d", d), arready[d], m_rphase == 0);
        chk($sformatf("rvalid%0d", d), rvalid[d], m_rphase == 2);
        if (m_rphase == 2) begin
          chk($sformatf("rdata%0d", d), rdata[d], m_rd[d]);
          chk($sformatf("rresp%0d", d), rresp[d], m_rr[d]);
        end
        chk($sformatf("param_wr%0d", d), pwr[d], m_pw[d]);
        if (m_pw[d]) chk($sformatf("param_idx%0d", d), pidx[d], m_pidx[d][1:0]);
      end
      chk("params4", params4, {m_regs[0][3], m_regs[0][2], m_regs[0][1], m_regs[0][0]});
      chk("params3", params3, {m_regs[1][2], m_regs[1][1], m_regs[1][0]});
    end
  end

  int pcnt [2] = '{0, 0};
  int pidx_log [$];
  always @(negedge aclk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (pwr[d] === 1'b1) begin
          pcnt[d]++;
          if (d == 0) pidx_log.push_back(int'(pidx[0]));
        end
      end
    end
  end

  // ---------------- master tasks ----------------
  task automatic send(input bit use_aw, input bit use_w, input logic [3:0] a,
                      input logic [31:0] dat, input logic [3:0] s);
    int t = 0;
    if (use_aw) begin awaddr = a; awvalid = 1'b1; end
    if (use_w) begin wdata = dat; wstrb = s; wvalid = 1'b1; end
    while ((use_aw && !awready[0]) || (use_w && !wready[0])) begin
      @(negedge aclk);
      if (++t > LIM) begin tmo("aw/w ready"); break; end
    end
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic get_b(input int hold, output logic [1:0] b0, output logic [1:0] b1);
    int t = 0;
    while (!bvalid[0]) begin
      @(negedge aclk);
      if (++t > LIM) begin tmo("bvalid"); break; end
    end
    b0 = bresp[0];
    b1 = bresp[1];
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("b_hold_valid", bvalid[0], 1'b1);
      chk("b_hold_resp", bresp[0], RESP_OKAY);
      chk("b_hold_awready", awready[0], 1'b0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] dat, input logic [3:0] s,
                    output logic [1:0] b0, output logic [1:0] b1);
    send(1'b1, 1'b1, a, dat, s);
    get_b(0, b0, b1);
  endtask

  task automatic get_r(output logic [31:0] d0, output logic [1:0] r0,
                       output logic [31:0] d1, output logic [1:0] r1);
    int t = 0;
    while (!rvalid[0]) begin
      @(negedge aclk);
      if (++t > LIM) begin tmo("rvalid"); break; end
    end
    d0 = rdata[0]; r0 = rresp[0]; d1 = rdata[1]; r1 = rresp[1];
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d0, output logic [1:0] r0,
                    output logic [31:0] d1, output logic [1:0] r1);
    int t = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready[0]) begin
      @(negedge aclk);
      if (++t > LIM) begin tmo("arready"); break; end
    end
    @(negedge aclk);
    arvalid = 1'b0;
    chk("r_latency_edge0", rvalid[0], 1'b0);
    @(negedge aclk);
    chk("r_latency_edge1", rvalid[0], 1'b1);
    get_r(d0, r0, d1, r1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] d0, d1;
  logic [1:0]  r0, r1, b0, b1;
  int          pc0, pc1, t;
  logic [31:0] wr_vals [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};

  initial begin
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk_en = 1'b1;
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_rresp", rresp[0], RESP_OKAY);
    chk("rst_bresp", bresp[0], RESP_OKAY);
    chk("rst_param_idx", pidx[0], 2'd0);
    chk("rst_params", params4, 128'h0);

    for (int a = 0; a < 4; a++) begin
      rd(4'(a * 4), d0, r0, d1, r1);
      chk("rst_read_data", d0, 32'h0);
      chk("rst_read_resp", r0, RESP_OKAY);
    end

    pidx_log.delete();
    pc0 = pcnt[0];
    for (int a = 0; a < 4; a++) begin
      wr(4'(a * 4), wr_vals[a], 4'hF, b0, b1);
      chk("wr_bresp", b0, RESP_OKAY);
    end
    chk("wr_pulse_count", 32'(pcnt[0] - pc0), 32'd4);
    for (int a = 0; a < 4; a++) begin
      if (a < pidx_log.size()) chk("wr_pulse_idx", 32'(pidx_log[a]), 32'(a));
      rd(4'(a * 4), d0, r0, d1, r1);
      chk("readback", d0, wr_vals[a]);
      chk("readback_resp", r0, RESP_OKAY);
    end
    chk("params_word1", params4[63:32], 32'habcd0001);

    wr(4'h8, 32'h12345678, 4'b0101, b0, b1);
    rd(4'h8, d0, r0, d1, r1);
    chk("strobe_merge", d0, 32'hde340078);
    wr(4'h8, 32'hdead0011, 4'hF, b0, b1);
    send(1'b0, 1'b1, 4'h0, 32'h12345678, 4'b0101);
    repeat (2) @(negedge aclk);
    send(1'b1, 1'b0, 4'h8, 32'h0, 4'h0);
    get_b(5, b0, b1);
    rd(4'hA, d0, r0, d1, r1);
    chk("w_first_merge", d0, 32'hde340078);
    wr(4'h8, 32'hdead0011, 4'h0, b0, b1);
    rd(4'h8, d0, r0, d1, r1);
    chk("zero_strobe_keep", d0, 32'hde340078);

    pc0 = pcnt[0];
    pc1 = pcnt[1];
    wr(4'hC, 32'h55aa55aa, 4'hF, b0, b1);
    chk("oor_bresp", b1, RESP_SLVERR);
    chk("inrange_bresp", b0, RESP_OKAY);
    chk("oor_no_pulse", 32'(pcnt[1] - pc1), 32'd0);
    chk("inrange_pulse", 32'(pcnt[0] - pc0), 32'd1);
    chk("oor_regs_kept", params3, {32'hde340078, 32'habcd0001, 32'h0101FFFF});
    rd(4'hC, d0, r0, d1, r1);
    chk("oor_rresp", r1, RESP_SLVERR);
    chk("oor_rdata", d1, 32'h0);
    chk("inrange_rdata", d0, 32'h55aa55aa);

    // AR lands on the very edge that commits the write to the same register
    awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h0; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    chk("coll_commit_edge", pwr[0], 1'b1);
    get_r(d0, r0, d1, r1);
    chk("coll_old_value", d0, 32'h0101FFFF);
    get_b(0, b0, b1);
    rd(4'h0, d0, r0, d1, r1);
    chk("coll_new_value", d0, 32'hCAFEF00D);

    awaddr = 4'h4; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    t = 0;
    while (!(bvalid[0] && rvalid[0])) begin
      @(negedge aclk);
      if (++t > LIM) begin tmo("b+r pending"); break; end
    end
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_bvalid", bvalid[0], 1'b0);
    chk("mid_rst_rvalid", rvalid[0], 1'b0);
    chk("mid_rst_readies", {awready[0], wready[0], arready[0]}, 3'b111);
    chk("mid_rst_params", params4, 128'h0);
    areset = 1'b0;
    rd(4'h4, d0, r0, d1, r1);
    chk("mid_rst_read", d0, 32'h0);

    repeat (2) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
